// File: rtl/sub_pipe_top.sv
`default_nettype none
// ============================================================================
// Module      : sub_pipe_top
// Description : Pipelined, chunked ripple-borrow subtractor that recovers the
//               operand a from an adder result: diff = sum - b.  One CHUNK-bit
//               slice is resolved per stage and the borrow is registered from
//               stage to stage.  Valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  operand width (sum is WIDTH+1 bits, diff is WIDTH bits)
//   CHUNK  bits resolved per pipeline stage; NCHUNK = ceil(WIDTH/CHUNK) >= 2
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   sum/b valid this cycle
//   in_ready   block accepts sum/b this cycle
//   sum        minuend, WIDTH+1 bits
//   b          subtrahend, WIDTH bits
//   out_valid  diff/error valid
//   out_ready  consumer accepts diff/error
//   diff       sum - b, low WIDTH bits (saturated when enabled)
//   error      result not representable in WIDTH bits
// Build option
//   SUB_PIPE_SATURATE_EN : underflow clamps diff to 0, overflow clamps diff to
//                          all ones; error is reported either way.
// ============================================================================
module sub_pipe_top #(
  parameter int WIDTH = 85,
  parameter int CHUNK = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             error
);

  localparam int NCHUNK  = (WIDTH + CHUNK - 1) / CHUNK;
  // Stages 0..NMID-1 resolve full CHUNK slices; the final stage is the
  // output register and resolves the remaining bits including bit WIDTH.
  localparam int NMID    = NCHUNK - 1;
  localparam int LAST_LO = NMID * CHUNK;
  localparam int LAST_W  = WIDTH + 1 - LAST_LO;

  // Each intermediate stage holds one word: bits below the resolved boundary
  // are finished difference bits, bits above are still raw sum bits.
  logic [NMID-1:0] v_q;
  logic [NMID-1:0] br_q;
  logic [WIDTH:0]  w_q  [NMID];
  logic [WIDTH:0]  bx_q [NMID];

  logic            adv;
  logic [NMID-1:0] vin;
  logic [NMID-1:0] bin_in;
  logic [NMID-1:0] br_nxt;
  logic [WIDTH:0]  x_in  [NMID];
  logic [WIDTH:0]  bx_in [NMID];
  logic [WIDTH:0]  w_nxt [NMID];
  logic [CHUNK:0]  t_mid;

  logic [LAST_W:0]  t_last;
  logic [WIDTH:0]   d_last;
  logic             bo_last;
  logic [WIDTH-1:0] diff_nxt;
  logic             err_nxt;

  // The pipeline moves as a whole; bubbles are not squeezed out.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Intermediate stage arithmetic
  always_comb begin
    t_mid  = '0;
    br_nxt = '0;
    vin    = '0;
    bin_in = '0;
    for (int k = 0; k < NMID; k++) begin
      x_in[k]  = '0;
      bx_in[k] = '0;
      w_nxt[k] = '0;
    end

    vin[0]   = in_valid;
    x_in[0]  = sum;
    bx_in[0] = {1'b0, b};
    bin_in[0] = 1'b0;
    for (int k = 1; k < NMID; k++) begin
      vin[k]    = v_q[k-1];
      x_in[k]   = w_q[k-1];
      bx_in[k]  = bx_q[k-1];
      bin_in[k] = br_q[k-1];
    end

    for (int k = 0; k < NMID; k++) begin
      t_mid = {1'b0, x_in[k][k*CHUNK +: CHUNK]}
            - {1'b0, bx_in[k][k*CHUNK +: CHUNK]}
            - {{CHUNK{1'b0}}, bin_in[k]};
      w_nxt[k]                   = x_in[k];
      w_nxt[k][k*CHUNK +: CHUNK] = t_mid[CHUNK-1:0];
      br_nxt[k]                  = t_mid[CHUNK];
    end
  end

  // Final stage: top slice including bit WIDTH (b is zero-extended there)
  always_comb begin
    t_last = {1'b0, w_q[NMID-1][WIDTH:LAST_LO]}
           - {1'b0, bx_q[NMID-1][WIDTH:LAST_LO]}
           - {{LAST_W{1'b0}}, br_q[NMID-1]};
    d_last  = {t_last[LAST_W-1:0], w_q[NMID-1][LAST_LO-1:0]};
    bo_last = t_last[LAST_W];
    err_nxt = bo_last | d_last[WIDTH];
`ifdef SUB_PIPE_SATURATE_EN
    if (bo_last) begin
      diff_nxt = '0;
    end else if (d_last[WIDTH]) begin
      diff_nxt = '1;
    end else begin
      diff_nxt = d_last[WIDTH-1:0];
    end
`else
    diff_nxt = d_last[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q       <= '0;
      br_q      <= '0;
      for (int k = 0; k < NMID; k++) begin
        w_q[k]  <= '0;
        bx_q[k] <= '0;
      end
      out_valid <= 1'b0;
      diff      <= '0;
      error     <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NMID; k++) begin
        v_q[k] <= vin[k];
        // Data only moves with a valid token so idle stages stay quiet.
        if (vin[k]) begin
          w_q[k]  <= w_nxt[k];
          bx_q[k] <= bx_in[k];
          br_q[k] <= br_nxt[k];
        end
      end
      out_valid <= v_q[NMID-1];
      if (v_q[NMID-1]) begin
        diff  <= diff_nxt;
        error <= err_nxt;
      end
    end
  end

endmodule
`default_nettype wire
